// File: rtl/fifo_param_pkg.sv
// Shared constants and helpers for the parametrised fall-through FIFO.
// Provides default geometry, a constant-foldable ceil-log2, and pointer wrap.
// Pointer wrap is explicit so DEPTH need not be a power of two.
package fifo_param_pkg;

  localparam int unsigned FIFO_DEF_WIDTH = 8;
  localparam int unsigned FIFO_DEF_DEPTH = 2;

  // Ceil-log2, usable in parameter expressions; clog2(1)=0, clog2(5)=3.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Next pointer value, wrapping from depth-1 back to 0.
  function automatic int unsigned ptr_next(input int unsigned p, input int unsigned depth);
    return (p >= depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/fifo_param_mem.sv
// Storage array for fifo_param: WIDTH x DEPTH, one sync write port, one async read port.
// Latency: write visible on the read port after the writing edge; read is combinational.
// No backpressure here; the controller decides when writes happen. Contents are never reset.
module fifo_param_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_dat
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Synchronous write of one entry; storage deliberately has no reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_param.sv
// First-word-fall-through FIFO with level count, almost flags and empty passthrough.
// Latency: stored word on q right after its write edge; when empty, d_in passes to q combinationally.
// Writes while full without a pop are dropped; pops while empty are ignored. Build option FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter  int unsigned WIDTH    = FIFO_DEF_WIDTH,
  parameter  int unsigned DEPTH    = FIFO_DEF_DEPTH,
  parameter  int unsigned AF_LEVEL = DEPTH - 1,
  parameter  int unsigned AE_LEVEL = 1,
  localparam int unsigned LW       = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_in_strobe,
  output logic [WIDTH-1:0] q,
  output logic             q_ready,
  input  logic             q_out_strobe,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr,
`endif
  output logic [LW-1:0]    level
);

  localparam int unsigned PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [LW-1:0] AF_W    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_W    = LW'(AE_LEVEL);
  localparam logic [LW-1:0] DEPTH_W = LW'(DEPTH);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_mem_dat;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == DEPTH_W);

  // Decide what actually happens this edge; a write+pop on an empty FIFO is a pure passthrough.
  always_comb begin
    w_pop  = q_out_strobe && !w_empty;
    w_push = 1'b0;
    if (w_empty) w_push = d_in_strobe && !q_out_strobe;
    else         w_push = d_in_strobe && (!w_full || q_out_strobe);
  end

  fifo_param_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_dat  (d_in),
    .i_rd_addr (r_rd_ptr),
    .o_rd_dat  (w_mem_dat)
  );

  // Pointers and level move together on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= PW'(ptr_next(32'(r_wr_ptr), DEPTH));
      if (w_pop)  r_rd_ptr <= PW'(ptr_next(32'(r_rd_ptr), DEPTH));
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign q            = w_empty ? d_in : w_mem_dat;
  assign q_ready      = rst_n && (w_empty ? d_in_strobe : 1'b1);
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_level <= AE_W);
  assign almost_full  = (r_level >= AF_W);
  assign level        = r_level;

`ifdef FIFO_ERR_FLAGS_EN
  logic w_drop;
  logic w_ignore;
  logic r_overflow;
  logic r_underflow;

  assign w_drop   = d_in_strobe && w_full && !q_out_strobe;
  assign w_ignore = q_out_strobe && w_empty && !d_in_strobe;

  // Sticky error flags; a new event on the clearing edge keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_drop)       r_overflow <= 1'b1;
      else if (err_clr) r_overflow <= 1'b0;
      if (w_ignore)     r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param at WIDTH=8, DEPTH=5 with a queue scoreboard.
// Error-flag checks are compiled in only when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_param;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int LW = 3;
  localparam int AF = D - 1;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  d_in = '0;
  logic          d_in_strobe = 1'b0;
  logic          q_out_strobe = 1'b0;
  logic [W-1:0]  q;
  logic          q_ready;
  logic          empty, full, almost_empty, almost_full;
  logic [LW-1:0] level;
`ifdef FIFO_ERR_FLAGS_EN
  logic          err_clr = 1'b0;
  logic          overflow, underflow;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] model_q[$];

  fifo_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .d_in         (d_in),
    .d_in_strobe  (d_in_strobe),
    .q            (q),
    .q_ready      (q_ready),
    .q_out_strobe (q_out_strobe),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr),
`endif
    .level        (level)
  );

  always #5 clk = ~clk;

  // One clock of stimulus: checks outputs before the edge, updates the scoreboard, checks state after.
  task automatic cycle(input bit wr, input logic [W-1:0] d, input bit rd, input bit clr);
    bit m_empty, m_full;
    logic [W-1:0] exp_dat;
    int sz;
    d_in = d; d_in_strobe = wr; q_out_strobe = rd;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = clr;
`endif
    #1;
    m_empty = (model_q.size() == 0);
    m_full  = (model_q.size() == D);
    n_checks++;
    if (m_empty) begin
      if (q_ready !== wr || (wr && q !== d)) begin
        n_fail++;
        $display("FAIL passthrough_pre: q_ready=%b q=%h, want q_ready=%b q=%h", q_ready, q, wr, d);
      end
    end else begin
      exp_dat = model_q[0];
      if (q_ready !== 1'b1 || q !== exp_dat) begin
        n_fail++;
        $display("FAIL head_pre: q_ready=%b q=%h, want q_ready=1 q=%h", q_ready, q, exp_dat);
      end
    end
    if (m_empty) begin
      if (wr && !rd) model_q.push_back(d);
    end else begin
      if (rd) void'(model_q.pop_front());
      if (wr && (!m_full || rd)) model_q.push_back(d);
    end
`ifdef FIFO_ERR_FLAGS_EN
    if (wr && m_full && !rd) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (rd && m_empty && !wr) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
`endif
    @(posedge clk); #1;
    d_in_strobe = 1'b0; q_out_strobe = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    #1;
    sz = model_q.size();
    n_checks++;
    if ({level, empty, full, almost_empty, almost_full} !==
        {LW'(sz), sz == 0, sz == D, sz <= AE, sz >= AF}) begin
      n_fail++;
      $display("FAIL state_post: level/e/f/ae/af=%0d/%b/%b/%b/%b, want %0d/%b/%b/%b/%b",
               level, empty, full, almost_empty, almost_full, sz, sz == 0, sz == D, sz <= AE, sz >= AF);
    end
    n_checks++;
    if (sz > 0) begin
      exp_dat = model_q[0];
      if (q_ready !== 1'b1 || q !== exp_dat) begin
        n_fail++;
        $display("FAIL head_post: q_ready=%b q=%h, want q_ready=1 q=%h", q_ready, q, exp_dat);
      end
    end else if (q_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: q_ready=%b, want 0", q_ready);
    end
`ifdef FIFO_ERR_FLAGS_EN
    n_checks++;
    if ({overflow, underflow} !== {m_ovf, m_unf}) begin
      n_fail++;
      $display("FAIL err_flags: ovf/unf=%b/%b, want %b/%b", overflow, underflow, m_ovf, m_unf);
    end
`endif
  endtask

  task automatic test_reset();
    d_in = 8'h3C; d_in_strobe = 1'b1;
    #12;
    n_checks++;
    if ({level, empty, full, almost_empty, almost_full, q_ready} !== {LW'(0), 5'b10100}) begin
      n_fail++;
      $display("FAIL reset_state: level/e/f/ae/af/rdy=%0d/%b/%b/%b/%b/%b, want 0/1/0/1/0/0",
               level, empty, full, almost_empty, almost_full, q_ready);
    end
    d_in_strobe = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_write_pop();
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    n_checks++;
    if (q !== 8'h55 || level !== LW'(1) || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL single_write: q=%h level=%0d empty=%b, want 55/1/0", q, level, empty);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_passthrough();
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    n_checks++;
    if (level !== LW'(0) || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL passthrough_post: level=%0d empty=%b, want 0/1", level, empty);
    end
  endtask

  task automatic test_fill_wrap();
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    n_checks++;
    if (full !== 1'b1 || level !== LW'(5) || almost_full !== 1'b1) begin
      n_fail++;
      $display("FAIL fill: full=%b level=%0d af=%b, want 1/5/1", full, level, almost_full);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 6; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_full_ops();
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h09, 1'b1, 1'b0);
    n_checks++;
    if (q !== 8'h02 || level !== LW'(5)) begin
      n_fail++;
      $display("FAIL full_wr_pop: q=%h level=%0d, want 02/5", q, level);
    end
    cycle(1'b1, 8'h0A, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    d_in_strobe = 1'b1; d_in = 8'h77;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (empty !== 1'b1 || level !== LW'(0) || q_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: empty=%b level=%0d q_ready=%b, want 1/0/0", empty, level, q_ready);
    end
    model_q.delete();
`ifdef FIFO_ERR_FLAGS_EN
    m_ovf = 1'b0; m_unf = 1'b0;
`endif
    d_in_strobe = 1'b0;
    #1 rst_n = 1'b1;
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_underflow();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (level !== LW'(0) || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_state: level=%0d empty=%b, want 0/1", level, empty);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0));
  endtask

  initial begin
    test_reset();
    test_write_pop();
    test_passthrough();
    test_fill_wrap();
    test_full_ops();
    test_async_reset();
    test_underflow();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
